neuron_row_mac: RTL



---
 rtl/neuron_row_mac_if.sv | 27 ++
 rtl/neuron_row_mac.sv | 127 ++++++++++++
 2 files changed

// File: rtl/neuron_row_mac_if.sv
// Handshake and ROM bus of neuron_row_mac: vector input, weight-row read, serial results.
interface neuron_row_mac_if #(
    parameter int M      = 8,
    parameter int N      = 16,
    parameter int ADDR_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [M*N-1:0]   x;
    logic [ADDR_W:0]  addr;
    logic [M*N-1:0]   W;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     y;
    logic [ADDR_W:0]  y_idx;
    logic             done;

    modport master (
        output in_valid, x, W, out_ready,
        input  in_ready, addr, out_valid, y, y_idx, done
    );

    modport slave (
        input  in_valid, x, W, out_ready,
        output in_ready, addr, out_valid, y, y_idx, done
    );
endinterface

// File: rtl/neuron_row_mac.sv
// Row-serial sign-magnitude Q6.9 dot-product engine reading weight rows from a combinational ROM.
// Optional ReLU on each result: define NEURON_ROW_MAC_RELU_EN.
module neuron_row_mac #(
    parameter int M      = 8,
    parameter int S      = 8,
    parameter int N      = 16,
    parameter int ADDR_W = 2,
    parameter int FRAC   = 9,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    neuron_row_mac_if.slave  bus
);
    localparam int KW    = (M > 1) ? $clog2(M) : 1;
    localparam int MAG_W = 2 * (N - 1);
    localparam logic signed [ACC_W-1:0] MAX_MAG = ACC_W'((1 << (N - 1)) - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state, state_nxt;
    logic [M*N-1:0]            x_p0;
    logic [KW-1:0]             k;
    logic [ADDR_W:0]           addr;
    logic signed [ACC_W-1:0]   acc_p0;
    logic signed [ACC_W-1:0]   prod_p0;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [N-1:0]              y_p1;
    logic                      done_q;
    logic                      accept, out_fire, k_last, row_last;

    // Sign-magnitude product, truncated back to Q6.9; a negated zero is still zero.
    function automatic logic signed [ACC_W-1:0] sm_product(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [MAG_W-1:0] full;
        logic [ACC_W-1:0] mag;
        full = a[N-2:0] * b[N-2:0];
        mag  = ACC_W'(full >> FRAC);
        return (a[N-1] ^ b[N-1]) ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic [N-1:0] to_sign_mag(input logic signed [ACC_W-1:0] v);
        logic [N-2:0] neg_mag;
        neg_mag = (N-1)'(-v);
        if (v > MAX_MAG)
            return {1'b0, {(N-1){1'b1}}};
        else if (v < -MAX_MAG)
            return {N{1'b1}};
        else if (v < 0)
            return {1'b1, neg_mag};
        else
            return {1'b0, v[N-2:0]};
    endfunction

    function automatic logic [N-1:0] relu(input logic [N-1:0] v);
`ifdef NEURON_ROW_MAC_RELU_EN
        return v[N-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign k_last   = (k == KW'(M - 1));
    assign row_last = (addr == (ADDR_W+1)'(S - 1));
    assign prod_p0  = sm_product(x_p0[k*N +: N], bus.W[k*N +: N]);
    assign acc_sum  = acc_p0 + prod_p0;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        out_fire  = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) begin
                accept    = 1'b1;
                state_nxt = MAC;
            end
            MAC: if (k_last) state_nxt = OUT;
            OUT: if (bus.out_ready) begin
                out_fire  = 1'b1;
                state_nxt = row_last ? IDLE : MAC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Stage p0: latched input vector, only captured on the accepting handshake
    always_ff @(posedge clk) begin
        if (accept) x_p0 <= bus.x;
    end

    // Stage p1: accumulate one element per MAC cycle, convert on the last element
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            k      <= '0;
            acc_p0 <= '0;
            y_p1   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= out_fire && row_last;
            if (accept) begin
                addr   <= '0;
                k      <= '0;
                acc_p0 <= '0;
            end else if (state == MAC) begin
                acc_p0 <= acc_sum;
                k      <= k_last ? '0 : k + 1'b1;
                if (k_last) y_p1 <= relu(to_sign_mag(acc_sum));
            end else if (out_fire && !row_last) begin
                addr   <= addr + 1'b1;
                k      <= '0;
                acc_p0 <= '0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.addr      = addr;
    assign bus.y         = y_p1;
    assign bus.y_idx     = addr;
    assign bus.done      = done_q;
endmodule
